// File: rtl/dvi_timing_pkg.sv
// Shared raster constants (640x480@60), scan state encoding and the sync bus
// type used by the DVI timing controller and its delay pipeline.
package dvi_timing_pkg;

  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_FP         = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BP         = 48;
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_FP         = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BP         = 33;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } scan_state_e;

  // Sync levels carried here already have the output polarity applied.
  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
  } sync_bus_t;

endpackage

// File: rtl/dvi_timing_controller_pipe.sv
// Fixed-latency shift register that re-aligns the decoded sync/blank bus with
// the renderer's pixel pipeline. DEPTH=0 degenerates to a wire.
module dvi_pipe_delay #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: these few stages are plain flops, so resetting every entry is cheap
    // and keeps the outputs blank right after reset; a real RAM would not be reset.
    always_ff @(posedge pclk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/dvi_timing_controller.sv
// Raster timing generator for the DVI transmitter: counters, delayed
// sync/blank, per-line prefetch requests and frame-aligned start/stop.
module dvi_timing_controller
  import dvi_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_blank,
  output logic       frame_start,
  output logic       line_req,
  output logic [8:0] line_num,
  input  logic       line_ack,
  output logic       running,
  output logic       underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_L   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_L   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_L   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_L   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_L = 10'(V_TOTAL - 1);

  localparam sync_bus_t IDLE_BUS = '{blank: 1'b1, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  scan_state_e state, state_next;
  logic        scanning;
  logic        h_wrap;
  logic        frame_end;
  logic [9:0]  v_next_line;
  logic        trigger;
  sync_bus_t   raw_bus, decoded_bus, delayed_bus;

  assign scanning    = (state != IDLE);
  assign h_wrap      = (hcount == H_LAST_L);
  assign frame_end   = h_wrap && (vcount == V_LAST_L);
  assign v_next_line = (vcount == V_LAST_L) ? 10'd0 : vcount + 10'd1;
  assign trigger     = scanning && (hcount == H_ACT_L) && (v_next_line < V_ACT_L);

  // NOTE: every clocked block uses <= so all registers sample pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next takes its hold value before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable) state_next = RUN;
      RUN:      if (!enable) state_next = STOPPING;
      STOPPING: begin
        if (enable)         state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Counters sit at (0,0) in IDLE, so leaving IDLE always starts a full frame.
  always_ff @(posedge pclk) begin
    if (rst || !scanning) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_wrap) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST_L) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // An ack on the wrap cycle is checked first, so it beats the underrun.
  always_ff @(posedge pclk) begin
    if (rst) begin
      line_req <= 1'b0;
      line_num <= '0;
      underrun <= 1'b0;
    end else if (trigger) begin
      line_req <= 1'b1;
      line_num <= v_next_line[8:0];
    end else if (line_req) begin
      if (line_ack) begin
        line_req <= 1'b0;
      end else if (scanning && h_wrap) begin
        line_req <= 1'b0;
        underrun <= 1'b1;
      end
    end
  end

  always_comb begin
    raw_bus = IDLE_BUS;
    if (scanning) begin
      raw_bus.blank = !((hcount < H_ACT_L) && (vcount < V_ACT_L));
      if ((hcount >= H_SS_L) && (hcount < H_SE_L)) raw_bus.hsync = SYNC_POL;
      if ((vcount >= V_SS_L) && (vcount < V_SE_L)) raw_bus.vsync = SYNC_POL;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) decoded_bus <= IDLE_BUS;
    else     decoded_bus <= raw_bus;
  end

  dvi_pipe_delay #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(IDLE_BUS)
  ) u_pipe_delay (
    .pclk(pclk),
    .rst (rst),
    .d   (decoded_bus),
    .q   (delayed_bus)
  );

  assign out_blank   = delayed_bus.blank;
  assign out_hsync   = delayed_bus.hsync;
  assign out_vsync   = delayed_bus.vsync;
  assign frame_start = scanning && (hcount == 10'd0) && (vcount == 10'd0);
  assign running     = scanning;

endmodule

// File: tb/tb_dvi_timing_controller.sv
// Scoreboard bench for dvi_timing_controller on a reduced raster: a linear
// pixel-position model predicts every cycle's outputs; a monitor compares.
`timescale 1ns/1ps
module tb_dvi_timing_controller;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 30, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PD = 2;
  localparam bit POL = 1'b0;
  localparam int WITHHELD_LINE = 10;

  logic       pclk = 1'b0;
  logic       rst = 1'b1, enable = 1'b1, line_ack = 1'b0;
  logic [9:0] hcount, vcount;
  logic       out_hsync, out_vsync, out_blank, frame_start, line_req, running, underrun;
  logic [8:0] line_num;

  dvi_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .PIPE_DELAY(PD)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable),
    .hcount(hcount), .vcount(vcount),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_blank(out_blank),
    .frame_start(frame_start), .line_req(line_req), .line_num(line_num),
    .line_ack(line_ack), .running(running), .underrun(underrun)
  );

  always #20 pclk = ~pclk;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       blank, hsync, vsync, fs, req;
    logic [8:0] num;
    logic       run, under;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0;
  int   fs_times[$];

  // Reference model: scan position as one linear pixel index into the frame.
  bit       m_scan, m_stop;
  int       m_pos;
  bit       m_req, m_under;
  int       m_num, m_age, m_delay;
  bit [2:0] m_pipe[$];
  int       ack_mode;  // 0: random delay, 1: withhold one line, 2: ack on the wrap cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit [2:0] raw_of(input bit scan, input int pos);
    int h, v;
    bit b, hs, vs;
    if (!scan) return {1'b1, ~POL, ~POL};
    h  = pos % HT;
    v  = pos / HT;
    b  = !(h < HA && v < VA);
    hs = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    vs = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
    return {b, hs, vs};
  endfunction

  task automatic model_reset();
    m_scan = 0; m_stop = 0; m_pos = 0;
    m_req = 0; m_under = 0; m_num = 0; m_age = 0; m_delay = 0;
    m_pipe.delete();
    for (int i = 0; i <= PD; i++) m_pipe.push_back({1'b1, ~POL, ~POL});
  endtask

  task automatic model_edge();
    int h, v, nv;
    bit eof;
    if (rst) begin
      model_reset();
      return;
    end
    h   = m_pos % HT;
    v   = m_pos / HT;
    nv  = (v + 1) % VT;
    eof = (m_pos == FRAME - 1);
    m_pipe.push_front(raw_of(m_scan, m_pos));
    void'(m_pipe.pop_back());
    if (m_scan && h == HA && nv < VA) begin
      m_req = 1; m_num = nv; m_age = 0; m_delay = $urandom_range(12, 0);
    end else begin
      if (m_req) begin
        if (line_ack) m_req = 0;
        else if (h == HT - 1) begin m_req = 0; m_under = 1; end
      end
      m_age++;
    end
    if (!m_scan) begin
      if (enable) m_scan = 1;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (enable) m_stop = 0;
      else if (m_stop && eof) begin m_scan = 0; m_stop = 0; end
      else m_stop = 1;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    bit [2:0] b;
    b = m_pipe[$];
    o = '{h: 10'(m_pos % HT), v: 10'(m_pos / HT), blank: b[2], hsync: b[1], vsync: b[0],
          fs: m_scan && m_pos == 0, req: m_req, num: 9'(m_num), run: m_scan, under: m_under};
    return o;
  endfunction

  task automatic step();
    if (m_req) begin
      case (ack_mode)
        1:       line_ack = (m_num != WITHHELD_LINE) && (m_age == m_delay);
        2:       line_ack = (m_pos % HT == HT - 1);
        default: line_ack = (m_age == m_delay);
      endcase
    end else begin
      line_ack = 1'($urandom_range(1, 0));
    end
    model_edge();
    exp_q.push_back(model_obs());
    @(posedge pclk);
    #1;
    cyc++;
    if (frame_start) fs_times.push_back(cyc);
  endtask

  task automatic run_until(input int target, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_scan && m_pos == target) && n < 3 * FRAME);
    if (!(m_scan && m_pos == target)) begin
      n_checks++;
      $display("FAIL %s: position %0d not reached in %0d cycles", tag, target, n);
    end
  endtask

  always @(negedge pclk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{h: hcount, v: vcount, blank: out_blank, hsync: out_hsync, vsync: out_vsync,
            fs: frame_start, req: line_req, num: line_num, run: running, under: underrun};
      check($sformatf("cycle_h%0d_v%0d", e.h, e.v), 64'(a), 64'(e));
    end
  end

  initial begin
    int n;
    ack_mode = 0;
    model_reset();

    // Reset held with enable high
    rst = 1'b1; enable = 1'b1;
    repeat (3) step();
    check("rst_blank", 64'(out_blank), 64'(1));
    check("rst_hsync", 64'(out_hsync), 64'(1));
    check("rst_vsync", 64'(out_vsync), 64'(1));
    check("rst_line_req", 64'(line_req), 64'(0));
    check("rst_running", 64'(running), 64'(0));

    // Free run: geometry and the line-0 prefetch at the end of the frame
    rst = 1'b0;
    fs_times.delete();
    run_until((VT - 1) * HT + HA + 1, "to_prefetch0");
    check("prefetch0_req", 64'(line_req), 64'(1));
    check("prefetch0_num", 64'(line_num), 64'(0));
    run_until(1, "to_frame2");
    check("frame_interval", 64'(fs_times.size() >= 2 ? fs_times[1] - fs_times[0] : 0), 64'(FRAME));
    check("no_underrun_prompt", 64'(underrun), 64'(0));

    // Underrun: the request for one line is never acked
    ack_mode = 1;
    run_until(WITHHELD_LINE * HT, "to_underrun");
    check("underrun_req_dropped", 64'(line_req), 64'(0));
    check("underrun_set", 64'(underrun), 64'(1));
    ack_mode = 0;
    run_until((WITHHELD_LINE + 4) * HT, "after_underrun");
    check("underrun_sticky", 64'(underrun), 64'(1));

    // Mid-frame reset, then acks that land exactly on the wrap cycle
    rst = 1'b1;
    step();
    check("midrst_hcount", 64'(hcount), 64'(0));
    check("midrst_running", 64'(running), 64'(0));
    check("midrst_underrun", 64'(underrun), 64'(0));
    check("midrst_blank", 64'(out_blank), 64'(1));
    step();
    rst = 1'b0;
    ack_mode = 2;
    run_until(FRAME - 1, "boundary_frame");
    step();
    check("boundary_ack_no_underrun", 64'(underrun), 64'(0));

    // Clean stop mid-frame: the frame completes before IDLE
    ack_mode = 0;
    run_until(10 * HT, "to_stop");
    enable = 1'b0;
    n = 0;
    while (m_scan && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("stop_cycles", 64'(n), 64'(FRAME - 10 * HT));
    check("stop_running", 64'(running), 64'(0));
    check("stop_hcount", 64'(hcount), 64'(0));
    check("stop_vcount", 64'(vcount), 64'(0));
    check("stop_no_frame_start", 64'(frame_start), 64'(0));
    repeat (20) step();

    // Re-enable while stopping: no gap, next frame starts normally
    enable = 1'b1;
    run_until(5 * HT, "to_restop");
    enable = 1'b0;
    repeat (200) step();
    enable = 1'b1;
    run_until(0, "to_next_frame");
    check("reenable_frame_start", 64'(frame_start), 64'(1));
    check("reenable_running", 64'(running), 64'(1));
    repeat (10) step();

    @(negedge pclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
